// File: rtl/key_note_arbiter.sv
// Arbitrates the shared note/display path between the live keypad and the
// playback sequencer; live input pre-empts playback and is followed by a quiet gap.
module key_note_arbiter #(
  parameter int HOLD_CYC = 25000000,
  parameter int GAP_CYC  = 5000000,
  parameter int CNT_W    = 25
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_pressed,
  input  logic [3:0] key_code,
  input  logic       play_valid,
  input  logic [3:0] play_note,
  output logic       play_ready,
  output logic       out_pressed,
  output logic [3:0] out_code,
  output logic       src_live,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LIVE = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_d;
  logic [3:0]       code_d;
  logic             live_d;

  // Handshake: play_note transfers on a rising edge where play_valid and
  // play_ready are both high; play_ready never depends on play_valid.
  assign play_ready = sys_rst_n & (state_q == S_IDLE) & ~key_pressed;
  assign busy       = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pressed_d = out_pressed;
    code_d    = out_code;
    live_d    = src_live;
    case (state_q)
      S_IDLE: begin
        if (key_pressed) begin
          state_d   = S_LIVE;
          pressed_d = 1'b1;
          code_d    = key_code;
          live_d    = 1'b1;
        end else if (play_valid) begin
          state_d   = S_PLAY;
          pressed_d = 1'b1;
          code_d    = play_note;
          cnt_d     = HOLD_LOAD;
        end else begin
          pressed_d = 1'b0;
        end
      end
      S_LIVE: begin
        if (key_pressed) begin
          code_d = key_code;
        end else begin
          // out_code deliberately keeps the last live code through the gap.
          state_d   = S_GAP;
          pressed_d = 1'b0;
          live_d    = 1'b0;
          cnt_d     = GAP_LOAD;
        end
      end
      S_PLAY: begin
        if (key_pressed) begin
          state_d   = S_LIVE;
          pressed_d = 1'b1;
          code_d    = key_code;
          live_d    = 1'b1;
        end else if (cnt_q == '0) begin
          state_d   = S_IDLE;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (key_pressed) begin
          state_d   = S_LIVE;
          pressed_d = 1'b1;
          code_d    = key_code;
          live_d    = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_pressed <= 1'b0;
      out_code    <= 4'h0;
      src_live    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_pressed <= pressed_d;
      out_code    <= code_d;
      src_live    <= live_d;
    end
  end

endmodule
